if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage and producer side of the IF/ID interface.
- Generates the sequential PC and issues word requests to instruction memory over a req/gnt + rvalid protocol.
- Buffers returned words with their PCs and presents them as if_pc/if_instr/if_valid to the IF/ID register.
- Honours stall (hold) and redirect (flush plus new PC) from the hazard/branch logic.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, entries in the fetch buffer (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
- stall  in  1  IF/ID not accepting; hold the presented entry.
- redirect  in  1  branch/jump taken; flush everything and restart at redirect_pc.
- redirect_pc  in  32  new fetch address.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address (bits[1:0]=0).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  presented entry valid.
- if_pc  out  32  PC of presented entry.
- if_instr  out  32  presented instruction.
- fetch_misaligned  out  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
  - fetch_misaligned=0, buffer empty, state IDLE.
  - fetch_pc=RESET_PC.
- Outputs when buffer empty: if_pc=0, if_instr=NOP, if_valid=0.
- Outputs are driven from the buffer head (registered storage, no combinational path from imem_rdata).
- FSM:
  - IDLE: if credit available, go to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_gnt: capture pc_inflight=fetch_pc, fetch_pc+=4 (wraps 32'hFFFF_FFFC -> 0), go to RESP.
  - RESP: wait for imem_rvalid, then push {pc_inflight, imem_rdata}.
    - Go to REQ if credit available, else IDLE.
  - DROP: outstanding response belongs to a flushed path. On imem_rvalid, discard it and go to REQ.
- Credit: at most one request outstanding. Issue only when buffer occupancy plus outstanding count < BUF_DEPTH. No push can ever find the buffer full.
- Handshake: imem_req/imem_addr stay stable until imem_gnt. A request is never withdrawn, except by redirect.
- Pop: if_valid && !stall at the clock edge pops the head. Push and pop in the same cycle are allowed; occupancy is unchanged.
- Stall: the head entry and the if_* outputs hold. Fetching continues until credit is exhausted.
- Redirect (highest priority, in any state):
  - Buffer cleared; if_valid=0 the next cycle.
  - fetch_pc=redirect_pc.
  - From REQ: the request is dropped. imem_req may deassert, or the address changes next cycle, since no gnt was taken.
  - From RESP: go to DROP.
  - From IDLE/REQ: go to REQ.
  - A response arriving in the same cycle as redirect is discarded.
  - Redirect while in DROP: update fetch_pc, stay in DROP.
- Redirect with stall: redirect wins. The buffer is flushed regardless of stall.
- Latency: when imem_gnt and imem_rvalid are each one cycle, the first if_valid appears 3 cycles after rst release. Steady-state throughput is 1 instruction every 2 cycles.
- Reset mid-operation: immediate return to reset values. Any in-flight response is lost. The memory side is also reset.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- With the macro: redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 (sticky until the next redirect or reset).
  - State goes to IDLE and no requests are issued.
  - if_valid=0.
- Without the macro:
  - fetch_misaligned tied to 0.
  - redirect_pc[1:0] ignored (forced to 2'b00).

Decomposition:
- Package rv32i_fetch_pkg:
  - RV32I_NOP=32'h0000_0013.
  - fetch_state_t enum {IDLE, REQ, RESP, DROP}.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_buf: synchronous FIFO of fetch_entry_t, BUF_DEPTH deep.
  - Ports: push, pop, clear, head, count, empty.
  - Same async active-low reset.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0093 at 0x0 -> imem_addr=0x0 asserted, then if_valid=1, if_pc=0x0, if_instr=0x00000093; next entry if_pc=0x4.
- stall=1 for 5 cycles after first entry -> if_pc/if_instr held at 0x0/0x00000093. Only one further gnt occurs; the buffer fills to 2 and imem_req stays low.
- Redirect to 0x100 while in RESP; old response 0xAAAAAAAA arrives 2 cycles later -> response discarded, if_valid=0, next imem_addr=0x100, first valid if_pc=0x100.
- Redirect with stall=1 and a full buffer -> next cycle if_valid=0, if_instr=NOP, if_pc=0.
- imem_gnt delayed 3 cycles -> imem_req and imem_addr=0x8 stable all 3 cycles, and pc advances once only.
- FETCH_MISALIGN_CHK_EN defined, redirect_pc=0x102 -> fetch_misaligned=1, no imem_req. A later redirect to 0x200 clears the flag and fetching resumes at 0x200.

Source files
------------

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32i_fetch_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, instr} entries with a flush input.
module fetch_buf
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         clear,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           full;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC, req/gnt/rvalid memory port, buffered IF/ID output.
// Optional FETCH_MISALIGN_CHK_EN flags misaligned redirect targets and halts fetching.
module if_fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_misaligned
);

    localparam int unsigned   CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    pc_inflight_q, pc_inflight_d;
    logic           misaligned_q, misaligned_d;

    logic           push;
    logic           pop;
    fetch_entry_t   push_entry;
    fetch_entry_t   buf_head;
    logic [CW-1:0]  buf_count;
    logic           buf_empty;
    logic [CW-1:0]  occ_after_push;
    logic           redirect_misaligned;
    fetch_state_t   restart_state;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_misaligned = |redirect_pc[1:0];
`else
    logic unused_redirect_lsb;
    assign redirect_misaligned = 1'b0;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    assign restart_state  = redirect_misaligned ? IDLE : REQ;
    assign pop            = if_valid && !stall;
    assign occ_after_push = buf_count + CW'(1) - CW'(pop);
    assign push_entry     = '{pc: pc_inflight_q, instr: imem_rdata};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_inflight_d = pc_inflight_q;
        misaligned_d  = misaligned_q;
        push          = 1'b0;

        if (redirect) begin
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            misaligned_d = redirect_misaligned;
            // A grant or response coinciding with redirect settles the outstanding slot now.
            unique case (state_q)
                IDLE:       state_d = restart_state;
                REQ:        state_d = imem_gnt ? DROP : restart_state;
                RESP, DROP: state_d = imem_rvalid ? restart_state : DROP;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!misaligned_q && buf_count < DEPTH_C) state_d = REQ;
                end
                REQ: begin
                    if (imem_gnt) begin
                        pc_inflight_d = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + 32'd4;
                        state_d       = RESP;
                    end
                end
                RESP: begin
                    if (imem_rvalid) begin
                        push    = 1'b1;
                        state_d = (occ_after_push < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) state_d = misaligned_q ? IDLE : REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            pc_inflight_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_inflight_q <= pc_inflight_d;
            misaligned_q  <= misaligned_d;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (redirect),
        .head       (buf_head),
        .count      (buf_count),
        .empty      (buf_empty)
    );

    assign imem_req         = (state_q == REQ);
    assign imem_addr        = fetch_pc_q;
    assign if_valid         = !buf_empty;
    assign if_pc            = buf_empty ? 32'h0 : buf_head.pc;
    assign if_instr         = buf_empty ? RV32I_NOP : buf_head.instr;
    assign fetch_misaligned = misaligned_q;

endmodule
